// File: rtl/seq_mult_unit.sv
// Shift-and-add sequential multiplier with its own controller: sign-magnitude operand
// capture, one add/shift per cycle, optional early exit, registered 2N-bit product.

module seq_mult_unit #(
  parameter int unsigned N          = 32,
  parameter bit          EARLY_EXIT = 1'b1,
  localparam int unsigned CW        = $clog2(N + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            signed_mode,
  input  logic [N-1:0]    multiplicand,
  input  logic [N-1:0]    multiplier,
  output logic            busy,
  output logic            done,
  output logic [2*N-1:0]  product,
  output logic [CW-1:0]   iter_count
);

  typedef enum logic [1:0] {StIdle, StCalc, StFin, StDone} state_e;

  state_e           state_q, state_d;
  logic             sign_q, sign_d;
  logic [2*N-1:0]   mcand_q, mcand_d;
  logic [N-1:0]     mplier_q, mplier_d;
  logic [2*N-1:0]   acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    iter_q, iter_d;
  logic [2*N-1:0]   product_q, product_d;
  logic [CW-1:0]    iter_count_q, iter_count_d;

  logic [N-1:0]     a_mag, b_mag;
  logic [N-1:0]     mplier_sh;
  logic [CW-1:0]    cnt_dec;
  logic             last_iter;

  // Magnitudes are taken as unsigned N-bit values, so -2^(N-1) maps to 2^(N-1) cleanly.
  always_comb begin
    a_mag = (signed_mode && multiplicand[N-1]) ? -multiplicand : multiplicand;
    b_mag = (signed_mode && multiplier[N-1])   ? -multiplier   : multiplier;
  end

  always_comb begin
    mplier_sh = mplier_q >> 1;
    cnt_dec   = cnt_q - CW'(1);
    last_iter = (cnt_dec == '0) || (EARLY_EXIT && (mplier_sh == '0));
  end

  always_comb begin
    state_d      = state_q;
    sign_d       = sign_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    iter_d       = iter_q;
    product_d    = product_q;
    iter_count_d = iter_count_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          sign_d   = signed_mode & (multiplicand[N-1] ^ multiplier[N-1]);
          mcand_d  = {{N{1'b0}}, a_mag};
          mplier_d = b_mag;
          acc_d    = '0;
          cnt_d    = CW'(N);
          iter_d   = '0;
          state_d  = StCalc;
        end else begin
          state_d  = StIdle;
        end
      end
      StCalc: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_sh;
        cnt_d    = cnt_dec;
        iter_d   = iter_q + CW'(1);
        if (last_iter) begin
          state_d = StFin;
        end
      end
      StFin: begin
        product_d    = sign_q ? -acc_q : acc_q;
        iter_count_d = iter_q;
        state_d      = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      sign_q       <= 1'b0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      iter_q       <= '0;
      product_q    <= '0;
      iter_count_q <= '0;
    end else begin
      state_q      <= state_d;
      sign_q       <= sign_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      iter_q       <= iter_d;
      product_q    <= product_d;
      iter_count_q <= iter_count_d;
    end
  end

  assign busy       = (state_q == StCalc) || (state_q == StFin);
  assign done       = (state_q == StDone);
  assign product    = product_q;
  assign iter_count = iter_count_q;

endmodule

// File: tb/tb_seq_mult_unit.sv
// Directed bench for seq_mult_unit: full-length and early-exit 32-bit instances plus an
// 8-bit early-exit instance, with a reference-product sweep at the end.

module tb_seq_mult_unit;

  logic        clk;
  logic        rst_n;
  logic        signed_mode;
  logic [31:0] a_in, b_in;
  logic        start_f, start_e, start_8;

  logic        busy_f, done_f, busy_e, done_e, busy_8, done_8;
  logic [63:0] prod_f, prod_e;
  logic [15:0] prod_8;
  logic [5:0]  ic_f, ic_e;
  logic [3:0]  ic_8;

  int checks = 0;
  int errors = 0;

  seq_mult_unit #(.N(32), .EARLY_EXIT(1'b0)) u_full (
    .clk(clk), .rst_n(rst_n), .start(start_f), .signed_mode(signed_mode),
    .multiplicand(a_in), .multiplier(b_in),
    .busy(busy_f), .done(done_f), .product(prod_f), .iter_count(ic_f)
  );

  seq_mult_unit #(.N(32), .EARLY_EXIT(1'b1)) u_early (
    .clk(clk), .rst_n(rst_n), .start(start_e), .signed_mode(signed_mode),
    .multiplicand(a_in), .multiplier(b_in),
    .busy(busy_e), .done(done_e), .product(prod_e), .iter_count(ic_e)
  );

  seq_mult_unit #(.N(8), .EARLY_EXIT(1'b1)) u_n8 (
    .clk(clk), .rst_n(rst_n), .start(start_8), .signed_mode(signed_mode),
    .multiplicand(a_in[7:0]), .multiplier(b_in[7:0]),
    .busy(busy_8), .done(done_8), .product(prod_8), .iter_count(ic_8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic f_done(input int s);
    case (s)
      0:       return done_f;
      1:       return done_e;
      default: return done_8;
    endcase
  endfunction

  function automatic logic [63:0] f_prod(input int s);
    case (s)
      0:       return prod_f;
      1:       return prod_e;
      default: return {48'b0, prod_8};
    endcase
  endfunction

  function automatic int f_ic(input int s);
    case (s)
      0:       return int'(ic_f);
      1:       return int'(ic_e);
      default: return int'(ic_8);
    endcase
  endfunction

  task automatic drive_start(input int s, input logic v);
    case (s)
      0:       start_f = v;
      1:       start_e = v;
      default: start_8 = v;
    endcase
  endtask

  // lat counts edges from the accept edge to the edge after which done is seen.
  task automatic run_op(input int s, input logic sm, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] prod, output int ic, output int lat);
    @(negedge clk);
    a_in = a;
    b_in = b;
    signed_mode = sm;
    drive_start(s, 1'b1);
    @(posedge clk);
    #1;
    drive_start(s, 1'b0);
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (f_done(s)) break;
    end
    prod = f_prod(s);
    ic   = f_ic(s);
  endtask

  logic [63:0] p, exp64;
  logic [15:0] e16, xa16, xb16;
  logic [31:0] mag32, ra, rb;
  logic [7:0]  mag8, b8;
  int          ic, lat, n_done, gap, k;

  initial begin
    rst_n = 1'b0;
    start_f = 1'b0;
    start_e = 1'b0;
    start_8 = 1'b0;
    signed_mode = 1'b0;
    a_in = '0;
    b_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {63'b0, busy_f | busy_e | busy_8}, 64'd0);
    check("rst_done", {63'b0, done_f | done_e | done_8}, 64'd0);
    check("rst_prod", prod_f | prod_e | {48'b0, prod_8}, 64'd0);
    check("rst_ic", {58'b0, ic_f | ic_e}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Unsigned full length
    run_op(0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, p, ic, lat);
    check("full_prod", p, 64'hFFFF_FFFE_0000_0001);
    check("full_ic", 64'(ic), 64'd32);
    check("full_lat", 64'(lat), 64'd33);

    // Reset while calculating
    @(negedge clk);
    a_in = 32'd7;
    b_in = 32'hFFFF_FFFF;
    signed_mode = 1'b0;
    start_f = 1'b1;
    @(posedge clk);
    #1;
    start_f = 1'b0;
    check("mid_busy", {63'b0, busy_f}, 64'd1);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", {63'b0, busy_f}, 64'd0);
    check("arst_done", {63'b0, done_f}, 64'd0);
    check("arst_prod", prod_f, 64'd0);
    check("arst_ic", {58'b0, ic_f}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done_f || done_e || done_8) n_done++;
    end
    check("arst_no_done", 64'(n_done), 64'd0);

    // Signed extremes
    run_op(0, 1'b1, 32'h8000_0000, 32'h8000_0000, p, ic, lat);
    check("smin_prod", p, 64'h4000_0000_0000_0000);
    check("smin_lat", 64'(lat), 64'd33);
    run_op(0, 1'b1, 32'hFFFF_FFFD, 32'd5, p, ic, lat);
    check("sneg_prod", p, 64'hFFFF_FFFF_FFFF_FFF1);
    check("sneg_ic", 64'(ic), 64'd32);
    run_op(1, 1'b1, 32'hFFFF_FFFD, 32'd5, p, ic, lat);
    check("e_sneg_prod", p, 64'hFFFF_FFFF_FFFF_FFF1);
    check("e_sneg_ic", 64'(ic), 64'd3);
    run_op(1, 1'b1, 32'd3, 32'hFFFF_FFFB, p, ic, lat);
    check("e_sbneg_prod", p, 64'hFFFF_FFFF_FFFF_FFF1);
    check("e_sbneg_lat", 64'(lat), 64'd4);
    run_op(1, 1'b1, 32'h8000_0000, 32'd1, p, ic, lat);
    check("e_smin1_prod", p, 64'hFFFF_FFFF_8000_0000);
    check("e_smin1_ic", 64'(ic), 64'd1);

    // Early exit
    run_op(1, 1'b0, 32'd1000, 32'd6, p, ic, lat);
    check("e6_prod", p, 64'd6000);
    check("e6_ic", 64'(ic), 64'd3);
    check("e6_lat", 64'(lat), 64'd4);
    run_op(1, 1'b0, 32'd1000, 32'd0, p, ic, lat);
    check("e0_prod", p, 64'd0);
    check("e0_ic", 64'(ic), 64'd1);
    check("e0_lat", 64'(lat), 64'd2);
    run_op(1, 1'b0, 32'd3, 32'h8000_0000, p, ic, lat);
    check("emsb_prod", p, 64'h1_8000_0000);
    check("emsb_ic", 64'(ic), 64'd32);

    // start pulsed while busy is ignored
    @(negedge clk);
    a_in = 32'd1000;
    b_in = 32'd6;
    signed_mode = 1'b0;
    start_e = 1'b1;
    @(posedge clk);
    #1;
    start_e = 1'b0;
    @(negedge clk);
    a_in = 32'd5;
    b_in = 32'd7;
    start_e = 1'b1;
    @(posedge clk);
    #1;
    start_e = 1'b0;
    lat = 1;
    while (lat < 100 && !done_e) begin
      @(posedge clk);
      lat++;
      #1;
    end
    check("ign_prod", prod_e, 64'd6000);
    check("ign_lat", 64'(lat), 64'd4);
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done_e) n_done++;
    end
    check("ign_no_second", 64'(n_done), 64'd0);

    // start held high through DONE
    @(negedge clk);
    a_in = 32'd1000;
    b_in = 32'd6;
    start_e = 1'b1;
    @(posedge clk);
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (done_e) break;
    end
    check("b2b_first_lat", 64'(lat), 64'd4);
    check("b2b_first_prod", prod_e, 64'd6000);
    a_in = 32'd3;
    b_in = 32'd5;
    @(posedge clk);
    #1;
    start_e = 1'b0;
    gap = 1;
    while (gap < 100 && !done_e) begin
      @(posedge clk);
      gap++;
      #1;
    end
    check("b2b_gap", 64'(gap), 64'd5);
    check("b2b_prod", prod_e, 64'd15);
    check("b2b_ic", {58'b0, ic_e}, 64'd3);

    // Reference sweep, N=8 and N=32, both modes
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 150; i++) begin
        ra = $urandom;
        rb = $urandom >> $urandom_range(0, 31);
        b8 = rb[7:0];
        xa16 = m[0] ? {{8{ra[7]}}, ra[7:0]} : {8'b0, ra[7:0]};
        xb16 = m[0] ? {{8{b8[7]}}, b8} : {8'b0, b8};
        e16 = xa16 * xb16;
        mag8 = (m[0] && b8[7]) ? -b8 : b8;
        k = 1;
        for (int j = 0; j < 8; j++) if (mag8[j]) k = j + 1;
        run_op(2, m[0], ra, rb, p, ic, lat);
        check("r8_prod", p, {48'b0, e16});
        check("r8_ic", 64'(ic), 64'(k));
        check("r8_lat", 64'(lat), 64'(k + 1));

        exp64 = (m[0] ? {{32{ra[31]}}, ra} : {32'b0, ra}) *
                (m[0] ? {{32{rb[31]}}, rb} : {32'b0, rb});
        mag32 = (m[0] && rb[31]) ? -rb : rb;
        k = 1;
        for (int j = 0; j < 32; j++) if (mag32[j]) k = j + 1;
        run_op(1, m[0], ra, rb, p, ic, lat);
        check("r32e_prod", p, exp64);
        check("r32e_ic", 64'(ic), 64'(k));
        check("r32e_lat", 64'(lat), 64'(k + 1));
        if (i < 40) begin
          run_op(0, m[0], ra, rb, p, ic, lat);
          check("r32f_prod", p, exp64);
          check("r32f_lat", 64'(lat), 64'd33);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
